vrf_stream: RTL

Parametrised streaming vector register file for the CV-X-IF vector unit. It holds NUM_VREGS vector registers of MAX_VL elements, each ELEN bits wide. Every read and write port runs its own element-sequencing state machine: one start command with a register index and a vector length, then one element per cycle under a valid/ready handshake, with a last-element flag and a done indication. It sits between the vector decode/issue stage and the vector lanes. Each port has its own counters, variable vl, back-pressure and a defined reset.

---
 rtl/vrf_pkg.sv | 20 ++
 rtl/vrf_port_seq.sv | 77 +++++++
 rtl/vrf_stream.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/vrf_pkg.sv
// Shared types, defaults and helpers for the streaming vector register file.
package vrf_pkg;

    localparam int unsigned DEF_NUM_RD    = 2;
    localparam int unsigned DEF_NUM_WR    = 1;
    localparam int unsigned DEF_NUM_VREGS = 32;
    localparam int unsigned DEF_MAX_VL    = 8;
    localparam int unsigned DEF_ELEN      = 8;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } fsm_state_e;

    // Requested element counts above the register length clamp to the register length.
    function automatic int unsigned sat_vl(input int unsigned vl, input int unsigned max_vl);
        return (vl > max_vl) ? max_vl : vl;
    endfunction

endpackage

// File: rtl/vrf_port_seq.sv
// Per-port element sequencer: start capture, element index, last flag and done pulse.
// Shared by read and write ports; the port type decides what step/finish mean.
module vrf_port_seq
    import vrf_pkg::*;
#(
    parameter int unsigned MAX_VL = DEF_MAX_VL,
    parameter int unsigned REG_W  = 5,
    parameter int unsigned VL_W   = 4,
    parameter int unsigned IDX_W  = 3
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             start_i,
    input  logic [REG_W-1:0] vreg_i,
    input  logic [VL_W-1:0]  vl_i,
    input  logic             step_i,
    input  logic             finish_i,
    output logic             busy_o,
    output logic             empty_o,
    output logic [REG_W-1:0] vreg_o,
    output logic [IDX_W-1:0] idx_o,
    output logic             last_o,
    output logic             done_o
);

    fsm_state_e       state_q;
    logic [REG_W-1:0] vreg_q;
    logic [VL_W-1:0]  vl_q;
    logic [IDX_W-1:0] idx_q;
    logic             done_q;
    logic [VL_W-1:0]  vl_sat;

    assign vl_sat = VL_W'(sat_vl(32'(vl_i), MAX_VL));

    assign busy_o  = (state_q == BUSY);
    assign empty_o = (vl_q == '0);
    assign vreg_o  = vreg_q;
    assign idx_o   = idx_q;
    assign done_o  = done_q;
    // The index points at the final element of a non-empty stream.
    assign last_o  = busy_o && !empty_o && (VL_W'(idx_q) == (vl_q - VL_W'(1)));

    // Port FSM: capture command on start, step the index, return to IDLE on finish or empty stream.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            vreg_q  <= '0;
            vl_q    <= '0;
            idx_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start_i) begin
                        state_q <= BUSY;
                        vreg_q  <= vreg_i;
                        vl_q    <= vl_sat;
                        idx_q   <= '0;
                    end
                end
                BUSY: begin
                    if (empty_o || finish_i) begin
                        state_q <= IDLE;
                        idx_q   <= '0;
                        done_q  <= 1'b1;
                    end else if (step_i && !last_o) begin
                        // Index stays parked on the last element so it never wraps.
                        idx_q <= idx_q + IDX_W'(1);
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: rtl/vrf_stream.sv
// Streaming vector register file: NUM_RD read and NUM_WR write ports, each
// sequencing one element per handshake through its own vrf_port_seq.
module vrf_stream
    import vrf_pkg::*;
#(
    parameter int unsigned NUM_RD    = DEF_NUM_RD,
    parameter int unsigned NUM_WR    = DEF_NUM_WR,
    parameter int unsigned NUM_VREGS = DEF_NUM_VREGS,
    parameter int unsigned MAX_VL    = DEF_MAX_VL,
    parameter int unsigned ELEN      = DEF_ELEN,
    localparam int unsigned REG_W    = $clog2(NUM_VREGS),
    localparam int unsigned VL_W     = $clog2(MAX_VL + 1),
    localparam int unsigned IDX_W    = (MAX_VL > 1) ? $clog2(MAX_VL) : 1
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic [NUM_RD-1:0]        rd_start_i,
    input  logic [NUM_RD*REG_W-1:0]  rd_vreg_i,
    input  logic [NUM_RD*VL_W-1:0]   rd_vl_i,
    output logic [NUM_RD-1:0]        rd_busy_o,
    output logic [NUM_RD-1:0]        rd_valid_o,
    input  logic [NUM_RD-1:0]        rd_ready_i,
    output logic [NUM_RD*ELEN-1:0]   rd_data_o,
    output logic [NUM_RD-1:0]        rd_last_o,
    input  logic [NUM_WR-1:0]        wr_start_i,
    input  logic [NUM_WR*REG_W-1:0]  wr_vreg_i,
    input  logic [NUM_WR*VL_W-1:0]   wr_vl_i,
    output logic [NUM_WR-1:0]        wr_busy_o,
    input  logic [NUM_WR-1:0]        wr_valid_i,
    output logic [NUM_WR-1:0]        wr_ready_o,
    input  logic [NUM_WR*ELEN-1:0]   wr_data_i,
    output logic [NUM_WR-1:0]        wr_done_o
);

    localparam int unsigned NP = NUM_RD + NUM_WR;

    // Sequencers are indexed reads first, then writes.
    logic [NP-1:0]             seq_start, seq_step, seq_fin;
    logic [NP-1:0]             seq_busy, seq_empty, seq_last, seq_done;
    logic [NP-1:0][REG_W-1:0]  seq_vreg_in, seq_vreg;
    logic [NP-1:0][VL_W-1:0]   seq_vl_in;
    logic [NP-1:0][IDX_W-1:0]  seq_idx;

    logic [ELEN-1:0]             mem_q [NUM_VREGS][MAX_VL];
    logic [NUM_RD-1:0]           rd_valid_q, rd_last_q, rd_fetch;
    logic [NUM_RD-1:0][ELEN-1:0] rd_data_q;
    logic [NUM_WR-1:0]           wr_we;

    for (genvar g = 0; g < NP; g++) begin : g_port
        if (g < NUM_RD) begin : g_rd
            assign seq_start[g]   = rd_start_i[g];
            assign seq_vreg_in[g] = rd_vreg_i[g*REG_W +: REG_W];
            assign seq_vl_in[g]   = rd_vl_i[g*VL_W +: VL_W];
            assign seq_step[g]    = rd_fetch[g];
            // A read stream ends on the handshake of its final element.
            assign seq_fin[g]     = rd_valid_q[g] & rd_ready_i[g] & rd_last_q[g];
        end else begin : g_wr
            localparam int unsigned W = g - NUM_RD;
            assign seq_start[g]   = wr_start_i[W];
            assign seq_vreg_in[g] = wr_vreg_i[W*REG_W +: REG_W];
            assign seq_vl_in[g]   = wr_vl_i[W*VL_W +: VL_W];
            assign seq_step[g]    = wr_we[W];
            assign seq_fin[g]     = wr_we[W] & seq_last[g];
        end

        vrf_port_seq #(
            .MAX_VL (MAX_VL),
            .REG_W  (REG_W),
            .VL_W   (VL_W),
            .IDX_W  (IDX_W)
        ) u_seq (
            .clk_i    (clk_i),
            .rst_ni   (rst_ni),
            .start_i  (seq_start[g]),
            .vreg_i   (seq_vreg_in[g]),
            .vl_i     (seq_vl_in[g]),
            .step_i   (seq_step[g]),
            .finish_i (seq_fin[g]),
            .busy_o   (seq_busy[g]),
            .empty_o  (seq_empty[g]),
            .vreg_o   (seq_vreg[g]),
            .idx_o    (seq_idx[g]),
            .last_o   (seq_last[g]),
            .done_o   (seq_done[g])
        );
    end

    // Fetch while elements remain and the output slot is free or draining.
    // Once the final element is loaded no further fetch happens.
    for (genvar r = 0; r < NUM_RD; r++) begin : g_fetch
        assign rd_fetch[r] = seq_busy[r] & ~seq_empty[r]
                           & ~(rd_valid_q[r] & rd_last_q[r])
                           & (~rd_valid_q[r] | rd_ready_i[r]);
        assign rd_data_o[r*ELEN +: ELEN] = rd_data_q[r];
    end

    for (genvar w = 0; w < NUM_WR; w++) begin : g_we
        assign wr_we[w] = wr_valid_i[w] & seq_busy[NUM_RD + w];
    end

    // Read output registers: load on fetch, clear on a consuming handshake, hold otherwise.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rd_valid_q <= '0;
            rd_last_q  <= '0;
            rd_data_q  <= '0;
        end else begin
            for (int r = 0; r < int'(NUM_RD); r++) begin
                if (rd_fetch[r]) begin
                    rd_data_q[r]  <= mem_q[seq_vreg[r]][seq_idx[r]];
                    rd_valid_q[r] <= 1'b1;
                    rd_last_q[r]  <= seq_last[r];
                end else if (rd_ready_i[r]) begin
                    rd_valid_q[r] <= 1'b0;
                    rd_last_q[r]  <= 1'b0;
                end
            end
        end
    end

    // Storage writes; walking ports high to low lets the lowest port win a collision.
    always_ff @(posedge clk_i) begin
        for (int w = int'(NUM_WR) - 1; w >= 0; w--) begin
            if (wr_we[w]) begin
                mem_q[seq_vreg[NUM_RD + w]][seq_idx[NUM_RD + w]] <= wr_data_i[w*ELEN +: ELEN];
            end
        end
    end

    assign rd_busy_o  = seq_busy[NUM_RD-1:0];
    assign rd_valid_o = rd_valid_q;
    assign rd_last_o  = rd_last_q;
    assign wr_busy_o  = seq_busy[NP-1:NUM_RD];
    assign wr_ready_o = seq_busy[NP-1:NUM_RD];
    assign wr_done_o  = seq_done[NP-1:NUM_RD];

    // Read ports have no done output and write ports handle empty streams inside the sequencer.
    logic unused_seq_bits;
    assign unused_seq_bits = ^{seq_done[NUM_RD-1:0], seq_empty[NP-1:NUM_RD]};

endmodule
